axi_stream_fcvt_w: RTL and testbench
====================================

# axi_stream_fcvt_w

Parametrised, fully back-pressured AXI4-stream float-to-integer converter that replaces the fixed-mode ftoi/floor units behind the `float` dispatch block. It converts IEEE-754 binary32 to 32-bit signed or unsigned integer under any of the five RISC-V rounding modes selected per transaction. It raises invalid/inexact flags, carries a dispatcher tag through unchanged, and sustains one result per cycle with a configurable pipeline depth.

## Interface
- STAGES, 2, pipeline depth in register stages, legal range 1..4.
- TAG_W, 4, width of the pass-through tag, minimum 1.

- clk  in  1  clock, all registers on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fcvt_tdata  in  32  binary32 operand.
- fcvt_tuser  in  4  [2:0] rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 behave as RNE), [3] 1 = unsigned result.
- fcvt_ttag  in  TAG_W  opaque tag, returned with the result.
- fcvt_tvalid  in  1  operand valid.
- fcvt_tready  out  1  operand accepted when high with tvalid.
- fcvt_r_tdata  out  32  integer result.
- fcvt_r_tuser  out  2  [0] invalid (NV), [1] inexact (NX).
- fcvt_r_ttag  out  TAG_W  tag of this result.
- fcvt_r_tvalid  out  1  result valid.
- fcvt_r_tready  in  1  consumer ready.

## Operation
- Pipeline of STAGES slots, each with a valid bit. Slot k advances when slot k+1 is empty or advancing. The last slot advances on fcvt_r_tready.
- fcvt_tready = !slot1_valid || slot1_advances; forced 0 while rst_n low. The path is combinational from fcvt_r_tready, with no skid buffer.
- Stage 1 work:
  - unpack sign/exponent/mantissa with the hidden bit;
  - align to an integer part plus guard bit and sticky bit.
- Stage 2 work (or the same stage when STAGES=1): round, negate, saturate, and form the flags.
- Stages 3..4 are pure delay registers.
- Exponent 0 means magnitude < 1; subnormals take their true value, so they round and set NX if nonzero.
- Round-up conditions, applied to magnitude m with guard g and sticky s:
  - RNE: g&&(s||lsb).
  - RTZ: never.
  - RDN: sign&&(g||s).
  - RUP: !sign&&(g||s).
  - RMM: g.
- NX = g||s, but only when the result is not saturated.
- Signed results:
  - NaN or value ≥ 2^31 after rounding gives 0x7FFFFFFF, NV=1.
  - Value < −2^31 after rounding gives 0x80000000, NV=1.
  - −2^31 exactly gives 0x80000000 with no flags.
- Unsigned results:
  - NaN, +inf, or ≥ 2^32 gives 0xFFFFFFFF, NV=1.
  - Negative value rounding to a nonzero magnitude gives 0, NV=1.
  - Negative value rounding to 0 gives 0, NX only.
- When NV=1, NX=0.
- Tag and flags travel in lock-step with data. Order is strictly preserved.

## Timing
- Reset is asynchronous. All slot valid bits clear immediately.
- Reset values: fcvt_r_tvalid=0, fcvt_r_tdata=0, fcvt_r_tuser=0, fcvt_r_ttag=0, fcvt_tready=0 while rst_n low.
- After rst_n rises, fcvt_tready=1 in the first cycle.
- Latency: an operand accepted in cycle N yields fcvt_r_tvalid=1 in cycle N+STAGES when there is no back-pressure. With STAGES=1 this is the next cycle.
- Throughput: 1 operand/cycle while fcvt_r_tready=1.
- While fcvt_r_tvalid && !fcvt_r_tready:
  - fcvt_r_tdata, tuser and ttag hold stable;
  - at most STAGES items are buffered;
  - fcvt_tready falls once all slots are full.
- Simultaneous accept in the same cycle that the full pipe drains: accepted, no bubble, no loss.
- Reset mid-stream discards in-flight items. No stale result appears after release.

## Test plan
- Rounding modes on 1.5 (0x3FC00000), signed:
  - RNE gives 2, RTZ gives 1, RDN gives 1, RUP gives 2, RMM gives 2.
  - NX=1 in every case.
- Ties and negatives:
  - 2.5 (0x40200000) RNE gives 2; RMM gives 3.
  - −2.5 (0xC0200000) RDN gives 0xFFFFFFFD; RUP gives 0xFFFFFFFE.
  - 4.0 (0x40800000) gives 4 with flags 00.
- Saturation, signed:
  - 2^31 (0x4F000000) gives 0x7FFFFFFF, NV=1.
  - −2^31 (0xCF000000) gives 0x80000000, flags 00.
- Saturation, unsigned:
  - NaN (0x7FC00000) gives 0xFFFFFFFF, NV=1.
  - −1.0 (0xBF800000) gives 0, NV=1.
  - −0.25 (0xBE800000) RTZ gives 0, NX=1.
- Throughput, STAGES=2, fcvt_r_tready=1:
  - Drive 16 back-to-back operands with tags 0..15.
  - First result appears 2 cycles after the first accept.
  - Then one result per cycle, tags in order.
- Back-pressure:
  - Stream 8 operands with fcvt_r_tready low for 5 cycles.
  - fcvt_tready drops after STAGES accepts and output is stable while stalled.
  - All 8 results arrive in order, none lost or duplicated.
- Reset mid-stream:
  - Pull rst_n low with 2 items in flight.
  - fcvt_r_tvalid=0 immediately.
  - After release, only newly accepted operands produce results.

Source files
------------

// File: rtl/axi_stream_fcvt_w.sv
// Back-pressured binary32 -> int32/uint32 converter with per-transaction RISC-V rounding.
// Stage 1 aligns the operand, stage 2 rounds and saturates, further stages only delay.
module axi_stream_fcvt_w #(
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      fcvt_tdata,
  input  logic [3:0]       fcvt_tuser,
  input  logic [TAG_W-1:0] fcvt_ttag,
  input  logic             fcvt_tvalid,
  output logic             fcvt_tready,
  output logic [31:0]      fcvt_r_tdata,
  output logic [1:0]       fcvt_r_tuser,
  output logic [TAG_W-1:0] fcvt_r_ttag,
  output logic             fcvt_r_tvalid,
  input  logic             fcvt_r_tready
);

  // Slots holding a finished result; with STAGES=1 the only slot is a result slot.
  localparam int NF = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int F0 = STAGES - NF + 1;

  typedef struct packed {
    logic        sign;
    logic        nan;
    logic        big;
    logic [31:0] mag;
    logic        g;
    logic        s;
  } align_t;

  // Fixed point with 24 fraction bits; magnitudes >= 2^32 (and inf/NaN) only set big.
  function automatic align_t f_align(input logic [31:0] x);
    align_t      a;
    logic [7:0]  ex;
    logic [23:0] sig;
    logic [55:0] fx;
    ex     = x[30:23];
    sig    = {(ex != 8'd0), x[22:0]};
    a      = '0;
    a.sign = x[31];
    fx     = '0;
    if (ex == 8'hFF) begin
      a.nan = (x[22:0] != 23'd0);
      a.big = 1'b1;
    end else if (ex >= 8'd159) begin
      a.big = 1'b1;
    end else if (ex >= 8'd126) begin
      fx    = {32'd0, sig} << (ex - 8'd126);
      a.mag = fx[55:24];
      a.g   = fx[23];
      a.s   = |fx[22:0];
    end else begin
      a.s = |sig;
    end
    return a;
  endfunction

  // Returns {nx, nv, data}.
  function automatic logic [33:0] f_round(input align_t a, input logic [2:0] rm,
                                          input logic uns);
    logic        up;
    logic [32:0] m;
    logic        inex;
    logic [31:0] d;
    logic        nv;
    logic        nx;
    case (rm)
      3'b001:  up = 1'b0;
      3'b010:  up = a.sign & (a.g | a.s);
      3'b011:  up = ~a.sign & (a.g | a.s);
      3'b100:  up = a.g;
      default: up = a.g & (a.s | a.mag[0]);
    endcase
    m    = {1'b0, a.mag} + {32'd0, up};
    inex = a.g | a.s;
    d    = '0;
    nv   = 1'b0;
    nx   = 1'b0;
    if (!uns) begin
      if (a.nan) begin
        d  = 32'h7FFF_FFFF;
        nv = 1'b1;
      end else if (a.big) begin
        d  = a.sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        nv = 1'b1;
      end else if (!a.sign) begin
        if (m[32] | m[31]) begin
          d  = 32'h7FFF_FFFF;
          nv = 1'b1;
        end else begin
          d  = m[31:0];
          nx = inex;
        end
      end else if (m > 33'h0_8000_0000) begin
        d  = 32'h8000_0000;
        nv = 1'b1;
      end else begin
        d  = 32'd0 - m[31:0];
        nx = inex;
      end
    end else begin
      if (a.nan) begin
        d  = 32'hFFFF_FFFF;
        nv = 1'b1;
      end else if (a.sign) begin
        if (a.big || (m != 33'd0)) nv = 1'b1;
        else                       nx = inex;
      end else if (a.big || m[32]) begin
        d  = 32'hFFFF_FFFF;
        nv = 1'b1;
      end else begin
        d  = m[31:0];
        nx = inex;
      end
    end
    return {nx, nv, d};
  endfunction

  logic [STAGES:1]   r_valid;
  logic [STAGES+1:1] w_ready;
  logic [STAGES:1]   w_load;

  // A slot can take new data if it or any slot downstream has a hole, or the sink is ready.
  always_comb begin : ready_chain
    logic full;
    full              = 1'b1;
    w_ready[STAGES+1] = fcvt_r_tready;
    for (int k = STAGES; k >= 1; k--) begin
      full       = full & r_valid[k];
      w_ready[k] = fcvt_r_tready | ~full;
    end
  end

  always_comb begin
    w_load    = '0;
    w_load[1] = fcvt_tvalid & w_ready[1];
    for (int k = 2; k <= STAGES; k++) begin
      w_load[k] = r_valid[k-1] & w_ready[k];
    end
  end

  assign fcvt_tready = rst_n & w_ready[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        r_valid[k] <= w_load[k] | (r_valid[k] & ~w_ready[k+1]);
      end
    end
  end

  logic [31:0]      w_res_data;
  logic [1:0]       w_res_flag;
  logic [TAG_W-1:0] w_res_tag;

  generate
    if (STAGES == 1) begin : g_single
      always_comb begin
        {w_res_flag, w_res_data} = f_round(f_align(fcvt_tdata), fcvt_tuser[2:0], fcvt_tuser[3]);
        w_res_tag                = fcvt_ttag;
      end
    end else begin : g_split
      align_t           r_s1_a;
      logic [2:0]       r_s1_rm;
      logic             r_s1_uns;
      logic [TAG_W-1:0] r_s1_tag;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s1_a   <= '0;
          r_s1_rm  <= '0;
          r_s1_uns <= 1'b0;
          r_s1_tag <= '0;
        end else if (w_load[1]) begin
          r_s1_a   <= f_align(fcvt_tdata);
          r_s1_rm  <= fcvt_tuser[2:0];
          r_s1_uns <= fcvt_tuser[3];
          r_s1_tag <= fcvt_ttag;
        end
      end

      always_comb begin
        {w_res_flag, w_res_data} = f_round(r_s1_a, r_s1_rm, r_s1_uns);
        w_res_tag                = r_s1_tag;
      end
    end
  endgenerate

  logic [31:0]      r_fdata [NF];
  logic [1:0]       r_fflag [NF];
  logic [TAG_W-1:0] r_ftag  [NF];
  logic [31:0]      w_sdata [NF];
  logic [1:0]       w_sflag [NF];
  logic [TAG_W-1:0] w_stag  [NF];

  always_comb begin
    w_sdata[0] = w_res_data;
    w_sflag[0] = w_res_flag;
    w_stag[0]  = w_res_tag;
    for (int j = 1; j < NF; j++) begin
      w_sdata[j] = r_fdata[j-1];
      w_sflag[j] = r_fflag[j-1];
      w_stag[j]  = r_ftag[j-1];
    end
  end

  // Result slots only load on an advance, so a stalled output holds steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NF; j++) begin
        r_fdata[j] <= '0;
        r_fflag[j] <= '0;
        r_ftag[j]  <= '0;
      end
    end else begin
      for (int j = 0; j < NF; j++) begin
        if (w_load[F0+j]) begin
          r_fdata[j] <= w_sdata[j];
          r_fflag[j] <= w_sflag[j];
          r_ftag[j]  <= w_stag[j];
        end
      end
    end
  end

  assign fcvt_r_tvalid = r_valid[STAGES];
  assign fcvt_r_tdata  = r_fdata[NF-1];
  assign fcvt_r_tuser  = r_fflag[NF-1];
  assign fcvt_r_ttag   = r_ftag[NF-1];

endmodule

// File: tb/tb_axi_stream_fcvt_w.sv
// Scoreboard bench for axi_stream_fcvt_w: directed vectors, throughput, stall, reset
// and a randomized run checked against a real-arithmetic rounding model.
module tb_axi_stream_fcvt_w;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      fcvt_tdata = '0;
  logic [3:0]       fcvt_tuser = '0;
  logic [TAG_W-1:0] fcvt_ttag = '0;
  logic             fcvt_tvalid = 1'b0;
  logic             fcvt_tready;
  logic [31:0]      fcvt_r_tdata;
  logic [1:0]       fcvt_r_tuser;
  logic [TAG_W-1:0] fcvt_r_ttag;
  logic             fcvt_r_tvalid;
  logic             fcvt_r_tready = 1'b1;

  always #5 clk = ~clk;

  axi_stream_fcvt_w #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .fcvt_tdata(fcvt_tdata), .fcvt_tuser(fcvt_tuser), .fcvt_ttag(fcvt_ttag),
    .fcvt_tvalid(fcvt_tvalid), .fcvt_tready(fcvt_tready),
    .fcvt_r_tdata(fcvt_r_tdata), .fcvt_r_tuser(fcvt_r_tuser), .fcvt_r_ttag(fcvt_r_ttag),
    .fcvt_r_tvalid(fcvt_r_tvalid), .fcvt_r_tready(fcvt_r_tready)
  );

  typedef struct {
    logic [31:0]      d;
    logic [1:0]       f;
    logic [TAG_W-1:0] t;
    int               cyc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          n_out = 0;
  logic [31:0] exp_d = '0;
  logic [1:0]  exp_f = '0;
  bit          chk_lat = 1'b0;
  bit          rand_bp = 1'b0;
  bit          bp_done = 1'b0;
  logic        prev_stall = 1'b0;
  logic [37:0] prev_out = '0;

  // Directed vectors: operand, {unsigned, rm}, expected data, expected {NX, NV}
  logic [31:0] dx [20] = '{32'h3FC00000, 32'h3FC00000, 32'h3FC00000, 32'h3FC00000, 32'h3FC00000,
                           32'h40200000, 32'h40200000, 32'hC0200000, 32'hC0200000, 32'h40800000,
                           32'h4F000000, 32'hCF000000, 32'h7FC00000, 32'hBF800000, 32'hBE800000,
                           32'h3FC00000, 32'h7F800000, 32'hFF800000, 32'h4F800000, 32'h80000001};
  logic [3:0]  du [20] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd4, 4'd2, 4'd3, 4'd0,
                           4'd0, 4'd0, 4'd8, 4'd8, 4'd9, 4'd5, 4'd0, 4'd8, 4'd8, 4'd2};
  logic [31:0] dd [20] = '{32'd2, 32'd1, 32'd1, 32'd2, 32'd2, 32'd2, 32'd3, 32'hFFFFFFFD,
                           32'hFFFFFFFE, 32'd4, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd0,
                           32'd0, 32'd2, 32'h7FFFFFFF, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [1:0]  df [20] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00,
                           2'b01, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic real p2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r * 0.5;
    return r;
  endfunction

  // Exact value as a real, rounded to an integer, then the saturation rules applied.
  task automatic model(input logic [31:0] x, input logic [3:0] u,
                       output logic [31:0] d, output logic [1:0] f);
    real        v, fl, cl, fr, r;
    int         ei, mi;
    bit         nan, inf, nx;
    logic [2:0] rm;
    longint     li;
    ei  = int'({24'd0, x[30:23]});
    mi  = int'({9'd0, x[22:0]});
    nan = (ei == 255) && (mi != 0);
    inf = (ei == 255) && (mi == 0);
    if (ei == 0) v = real'(mi) * p2(-149);
    else         v = (real'(mi) + 8388608.0) * p2(ei - 150);
    if (inf) v = 1.0e20;
    if (x[31]) v = -v;
    rm = (u[2:0] > 3'd4) ? 3'd0 : u[2:0];
    fl = $floor(v);
    cl = $ceil(v);
    fr = v - fl;
    case (rm)
      3'd1:    r = (v < 0.0) ? cl : fl;
      3'd2:    r = fl;
      3'd3:    r = cl;
      3'd4:    r = (fr < 0.5) ? fl : (fr > 0.5) ? cl : ((v < 0.0) ? fl : cl);
      default: begin
        if (fr < 0.5)      r = fl;
        else if (fr > 0.5) r = cl;
        else begin
          li = longint'(fl);
          r  = (li % 2 == 0) ? fl : cl;
        end
      end
    endcase
    nx = (r != v);
    d  = '0;
    f  = '0;
    if (!u[3]) begin
      if (nan || r >= 2147483648.0) begin d = 32'h7FFFFFFF; f = 2'b01; end
      else if (r < -2147483648.0)   begin d = 32'h80000000; f = 2'b01; end
      else begin li = longint'(r); d = li[31:0]; f = {nx, 1'b0}; end
    end else begin
      if (nan || r >= 4294967296.0) begin d = 32'hFFFFFFFF; f = 2'b01; end
      else if (r < 0.0)             begin d = 32'd0; f = 2'b01; end
      else begin li = longint'(r); d = li[31:0]; f = {nx, 1'b0}; end
    end
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] sp [12];
    logic [22:0] m;
    logic [7:0]  e;
    int          s;
    sp = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h4F000000,
           32'hCF000000, 32'h4F800000, 32'hCF000001, 32'h4EFFFFFF, 32'h00000001, 32'h80000001};
    s = $urandom_range(0, 9);
    if (s == 0) return $urandom;
    if (s == 1) return sp[$urandom_range(0, 11)];
    e = 8'($urandom_range(100, 165));
    m = 23'($urandom);
    if ($urandom_range(0, 1) == 1) m = m & (23'h7FFFFF << $urandom_range(0, 22));
    return {1'($urandom), e, m};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus side of the scoreboard: every accepted operand pushes its expected result.
  always @(negedge clk) begin : accept_mon
    exp_t e;
    if (rst_n && fcvt_tvalid && fcvt_tready) begin
      e.d   = exp_d;
      e.f   = exp_f;
      e.t   = fcvt_ttag;
      e.cyc = cyc;
      sb.push_back(e);
      n_acc++;
    end
  end

  always @(negedge clk) begin : result_mon
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", 64'({fcvt_r_tvalid, fcvt_r_tdata, fcvt_r_tuser, fcvt_r_ttag}),
              64'({1'b1, prev_out}));
      if (fcvt_r_tvalid && fcvt_r_tready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got tag %0d data %0h, required no result",
                   fcvt_r_ttag, fcvt_r_tdata);
        end else begin
          e = sb.pop_front();
          check("result", 64'({fcvt_r_tdata, fcvt_r_tuser, fcvt_r_ttag}), 64'({e.d, e.f, e.t}));
          if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'(STAGES));
          n_out++;
        end
      end
      prev_stall = fcvt_r_tvalid && !fcvt_r_tready;
      prev_out   = {fcvt_r_tdata, fcvt_r_tuser, fcvt_r_ttag};
    end
  end

  task automatic send(input logic [31:0] x, input logic [3:0] u, input logic [TAG_W-1:0] t,
                      input logic [31:0] ed, input logic [1:0] ef);
    int n;
    fcvt_tdata  = x;
    fcvt_tuser  = u;
    fcvt_ttag   = t;
    exp_d       = ed;
    exp_f       = ef;
    fcvt_tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!fcvt_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!fcvt_tready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: tready 0 after %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    fcvt_tvalid = 1'b0;
  endtask

  task automatic send_model(input logic [31:0] x, input logic [3:0] u, input logic [TAG_W-1:0] t);
    logic [31:0] ed;
    logic [1:0]  ef;
    model(x, u, ed, ef);
    send(x, u, t, ed, ef);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || fcvt_r_tvalid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0 || fcvt_r_tvalid) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n0, a0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(fcvt_r_tvalid), 64'(0));
    check("rst_tdata", 64'(fcvt_r_tdata), 64'(0));
    check("rst_tuser", 64'(fcvt_r_tuser), 64'(0));
    check("rst_ttag", 64'(fcvt_r_ttag), 64'(0));
    check("rst_tready", 64'(fcvt_tready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_tready", 64'(fcvt_tready), 64'(1));
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) send(dx[i], du[i], TAG_W'(i), dd[i], df[i]);
    wait_drain();

    chk_lat = 1'b1;
    n0 = n_out;
    c0 = cyc;
    for (int i = 0; i < 16; i++) send_model(rand_op(), 4'($urandom), TAG_W'(i));
    check("b2b_accept_cycles", 64'(cyc - c0), 64'(16));
    wait_drain();
    chk_lat = 1'b0;
    check("b2b_count", 64'(n_out - n0), 64'(16));

    fcvt_r_tready = 1'b0;
    n0 = n_out;
    a0 = n_acc;
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_model(rand_op(), 4'($urandom), TAG_W'(i));
        bp_done = 1'b1;
      end
    join_none
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("bp_accepts", 64'(n_acc - a0), 64'(STAGES));
    check("bp_tready_low", 64'(fcvt_tready), 64'(0));
    @(posedge clk);
    #1;
    fcvt_r_tready = 1'b1;
    for (int n = 0; n < 200 && !bp_done; n++) @(posedge clk);
    #1;
    check("bp_sender_done", 64'(bp_done), 64'(1));
    wait_drain();
    check("bp_count", 64'(n_out - n0), 64'(8));

    fcvt_r_tready = 1'b0;
    send_model(32'h3FC00000, 4'd0, 4'd1);
    send_model(32'h40800000, 4'd0, 4'd2);
    check("inflight_valid", 64'(fcvt_r_tvalid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 64'(fcvt_r_tvalid), 64'(0));
    check("midrst_tdata", 64'(fcvt_r_tdata), 64'(0));
    check("midrst_tready", 64'(fcvt_tready), 64'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_release_tready", 64'(fcvt_tready), 64'(1));
    @(posedge clk);
    #1;
    fcvt_r_tready = 1'b1;
    n0 = n_out;
    send_model(32'h40200000, 4'd4, 4'd10);
    send_model(32'hC0200000, 4'd2, 4'd11);
    send_model(32'h00000000, 4'd0, 4'd12);
    wait_drain();
    check("midrst_count", 64'(n_out - n0), 64'(3));

    rand_bp = 1'b1;
    fork
      begin
        while (rand_bp) begin
          @(posedge clk);
          #1;
          fcvt_r_tready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    n0 = n_out;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_model(rand_op(), 4'($urandom), TAG_W'($urandom));
    end
    rand_bp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    fcvt_r_tready = 1'b1;
    wait_drain();
    check("rand_count", 64'(n_out - n0), 64'(400));
    check("queue_empty", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
